chip_valve_seq: RTL

- Parametrised valve/pump sequencer for the ChIP chip generation with SIZE ring channels.
- Replaces static per-pad control wiring with a clocked controller.
- Accepts one fluidic command at a time: fill, pump, flush or collect on one channel.
- Drives the ctrl pad nets (inlet, outlet, flush, collect valves, peristaltic pump) with settle timing, then signals completion.

---
 rtl/chip_seq_pkg.sv | 25 ++
 rtl/chip_valve_seq_if.sv | 53 +++++
 rtl/chip_pump_phaser.sv | 57 +++++
 rtl/chip_valve_seq.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/chip_seq_pkg.sv
// Shared types and constants for the ChIP valve/pump sequencer.
package chip_seq_pkg;

    typedef enum logic [1:0] {
        OpFill    = 2'd0,
        OpPump    = 2'd1,
        OpFlush   = 2'd2,
        OpCollect = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        StIdle,
        StOpen,
        StRun,
        StClose
    } state_e;

    // Actuation level that closes a valve.
    localparam logic CLOSED = 1'b1;

    function automatic int unsigned clog2_min1(input int unsigned v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/chip_valve_seq_if.sv
// Command and pad-control bundle of chip_valve_seq; abort exists only with CHIP_SEQ_ABORT_EN.
interface chip_valve_seq_if
    import chip_seq_pkg::*;
#(
    parameter int unsigned SIZE        = 3,
    parameter int unsigned PUMP_PHASES = 3,
    parameter int unsigned CNT_W       = 16
);
    localparam int unsigned CH_W = clog2_min1(SIZE);

    logic                   cmd_valid;
    logic                   cmd_ready;
    op_e                    cmd_op;
    logic [CH_W-1:0]        cmd_chan;
    logic [CNT_W-1:0]       cmd_len;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [SIZE-1:0]        ctrl_inlet;
    logic [SIZE-1:0]        ctrl_outlet;
    logic [SIZE-1:0]        ctrl_flush;
    logic [SIZE-1:0]        ctrl_collect;
    logic [PUMP_PHASES-1:0] pump;

`ifdef CHIP_SEQ_ABORT_EN
    logic                   abort;

    modport master (
        output cmd_valid, cmd_op, cmd_chan, cmd_len, abort,
        input  cmd_ready, busy, done, err,
        input  ctrl_inlet, ctrl_outlet, ctrl_flush, ctrl_collect, pump
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chan, cmd_len, abort,
        output cmd_ready, busy, done, err,
        output ctrl_inlet, ctrl_outlet, ctrl_flush, ctrl_collect, pump
    );
`else
    modport master (
        output cmd_valid, cmd_op, cmd_chan, cmd_len,
        input  cmd_ready, busy, done, err,
        input  ctrl_inlet, ctrl_outlet, ctrl_flush, ctrl_collect, pump
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_chan, cmd_len,
        output cmd_ready, busy, done, err,
        output ctrl_inlet, ctrl_outlet, ctrl_flush, ctrl_collect, pump
    );
`endif

endinterface

// File: rtl/chip_pump_phaser.sv
// Rotating one-cold peristaltic pump pattern; o_step marks the last cycle of each phase.
module chip_pump_phaser
    import chip_seq_pkg::*;
#(
    parameter int unsigned PUMP_PHASES = 3,
    parameter int unsigned PHASE_DIV   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_en,
    output logic [PUMP_PHASES-1:0] o_pattern,
    output logic                   o_step
);
    localparam int unsigned DivW = clog2_min1(PHASE_DIV);
    localparam int unsigned PhW  = clog2_min1(PUMP_PHASES);

    logic                   r_active, w_active_d;
    logic [DivW-1:0]        r_div, w_div_d;
    logic [PhW-1:0]         r_phase, w_phase_d;
    logic [PUMP_PHASES-1:0] r_pattern, w_pattern_d;
    logic                   w_step;

    // i_en reflects the next cycle, so the registers always describe the current cycle.
    always_comb begin
        w_step     = r_active && (r_div == DivW'(PHASE_DIV - 1));
        w_active_d = i_en;
        w_div_d    = '0;
        w_phase_d  = '0;
        if (i_en && r_active) begin
            if (w_step) begin
                w_phase_d = (r_phase == PhW'(PUMP_PHASES - 1)) ? '0 : r_phase + 1'b1;
            end else begin
                w_div_d   = r_div + 1'b1;
                w_phase_d = r_phase;
            end
        end
        w_pattern_d = i_en ? ~(PUMP_PHASES'(1) << w_phase_d) : {PUMP_PHASES{CLOSED}};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_active  <= 1'b0;
            r_div     <= '0;
            r_phase   <= '0;
            r_pattern <= {PUMP_PHASES{CLOSED}};
        end else begin
            r_active  <= w_active_d;
            r_div     <= w_div_d;
            r_phase   <= w_phase_d;
            r_pattern <= w_pattern_d;
        end
    end

    assign o_pattern = r_pattern;
    assign o_step    = w_step;

endmodule

// File: rtl/chip_valve_seq.sv
// Valve/pump sequencer: IDLE -> OPEN -> RUN -> CLOSE with settle timing.
// Optional abort input enabled by defining CHIP_SEQ_ABORT_EN.
module chip_valve_seq
    import chip_seq_pkg::*;
#(
    parameter int unsigned SIZE        = 3,
    parameter int unsigned PUMP_PHASES = 3,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned SETTLE      = 2,
    parameter int unsigned PHASE_DIV   = 4
) (
    input  logic           clk,
    input  logic           rst,
    chip_valve_seq_if.slave bus
);
    localparam int unsigned      CH_W       = clog2_min1(SIZE);
    localparam logic [CNT_W-1:0] SettleLast = CNT_W'(SETTLE - 1);

    state_e           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [CNT_W-1:0] r_len, w_len_d;
    op_e              r_op, w_op_d;
    logic [CH_W-1:0]  r_chan, w_chan_d;

    logic             r_ready, r_busy, r_done, r_err;
    logic             w_ready_d, w_busy_d, w_done_d, w_err_d;
    logic [SIZE-1:0]  r_inlet, r_outlet, r_flush, r_collect;
    logic [SIZE-1:0]  w_inlet_d, w_outlet_d, w_flush_d, w_collect_d;
    logic [SIZE-1:0]  w_open_mask;

    logic                   w_pump_op, w_step, w_pump_en;
    logic [PUMP_PHASES-1:0] w_pump_pat;

    assign w_pump_op = (r_op == OpPump) || (r_op == OpCollect);
    assign w_pump_en = (w_state_d == StRun) && w_pump_op;

    chip_pump_phaser #(
        .PUMP_PHASES (PUMP_PHASES),
        .PHASE_DIV   (PHASE_DIV)
    ) u_phaser (
        .clk       (clk),
        .rst       (rst),
        .i_en      (w_pump_en),
        .o_pattern (w_pump_pat),
        .o_step    (w_step)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_len   <= '0;
            r_op    <= OpFill;
            r_chan  <= '0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_len   <= w_len_d;
            r_op    <= w_op_d;
            r_chan  <= w_chan_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_len_d   = r_len;
        w_op_d    = r_op;
        w_chan_d  = r_chan;
        w_done_d  = 1'b0;
        w_err_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.cmd_valid) begin
                    if (32'(bus.cmd_chan) >= SIZE) begin
                        w_err_d = 1'b1;
                    end else if (bus.cmd_len == '0) begin
                        w_done_d = 1'b1;
                    end else begin
                        w_state_d = StOpen;
                        w_cnt_d   = SettleLast;
                        w_len_d   = bus.cmd_len;
                        w_op_d    = bus.cmd_op;
                        w_chan_d  = bus.cmd_chan;
                    end
                end
            end
            StOpen: begin
                if (r_cnt == '0) begin
                    w_state_d = StRun;
                    w_cnt_d   = r_len - 1'b1;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
            StRun: begin
                // Pump ops count phase steps; the phaser supplies the divided step pulse.
                if (!w_pump_op || w_step) begin
                    if (r_cnt == '0) begin
                        w_state_d = StClose;
                        w_cnt_d   = SettleLast;
                    end else begin
                        w_cnt_d = r_cnt - 1'b1;
                    end
                end
            end
            StClose: begin
                if (r_cnt == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_cnt_d = r_cnt - 1'b1;
                end
            end
        endcase
`ifdef CHIP_SEQ_ABORT_EN
        if (bus.abort && (r_state == StOpen || r_state == StRun)) begin
            w_state_d = StClose;
            w_cnt_d   = SettleLast;
        end
`endif
        w_done_d = w_done_d || (w_state_d == StClose && w_cnt_d == '0);
    end

    always_comb begin
        w_ready_d   = (w_state_d == StIdle);
        w_busy_d    = (w_state_d != StIdle);
        w_open_mask = ~(SIZE'(1) << w_chan_d);
        w_inlet_d   = {SIZE{CLOSED}};
        w_outlet_d  = {SIZE{CLOSED}};
        w_flush_d   = {SIZE{CLOSED}};
        w_collect_d = {SIZE{CLOSED}};
        if (w_state_d == StOpen || w_state_d == StRun) begin
            unique case (w_op_d)
                OpFill, OpPump: begin
                    w_inlet_d  = w_open_mask;
                    w_outlet_d = w_open_mask;
                end
                OpFlush: begin
                    w_flush_d  = w_open_mask;
                    w_outlet_d = w_open_mask;
                end
                OpCollect: begin
                    w_collect_d = w_open_mask;
                    w_inlet_d   = w_open_mask;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_inlet   <= {SIZE{CLOSED}};
            r_outlet  <= {SIZE{CLOSED}};
            r_flush   <= {SIZE{CLOSED}};
            r_collect <= {SIZE{CLOSED}};
        end else begin
            r_ready   <= w_ready_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_err     <= w_err_d;
            r_inlet   <= w_inlet_d;
            r_outlet  <= w_outlet_d;
            r_flush   <= w_flush_d;
            r_collect <= w_collect_d;
        end
    end

    assign bus.cmd_ready    = r_ready;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.err          = r_err;
    assign bus.ctrl_inlet   = r_inlet;
    assign bus.ctrl_outlet  = r_outlet;
    assign bus.ctrl_flush   = r_flush;
    assign bus.ctrl_collect = r_collect;
    assign bus.pump         = w_pump_pat;

endmodule
